mul_iter_unit: RTL

- Iterative multiply/multiply-accumulate unit for ARM MUL/MLA, sitting directly downstream of register_file.
- Operands come from the register file read ports plus an accumulator operand.
- Result and destination address are returned to the register-file write port on completion.
- Holds the core stalled while busy.
- Shift-add, BITS_PER_CYCLE multiplier bits consumed per cycle, low 32 bits of the product only.

---
 rtl/mul_iter_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for MUL/MLA. Retires BITS_PER_CYCLE
// multiplier bits per RUN cycle and keeps the low 32 bits of the product.
// Handshake: i_start_w is taken in any state other than RUN; the unit then
// stalls the core while busy and reports the result with a one-cycle
// o_done_w pulse that carries the register-file write and N/Z strobes.
module mul_iter_unit #(
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_TERM     = 1'b0
) (
  input  logic        i_clk_w,
  input  logic        i_rst_w,
  input  logic        i_start_w,
  input  logic        i_accumulate_w,
  input  logic        i_set_flags_w,
  input  logic [31:0] i_op_a_w,
  input  logic [31:0] i_op_b_w,
  input  logic [31:0] i_acc_w,
  input  logic [3:0]  i_dest_addr_w,
  output logic        o_busy_w,
  output logic        o_stall_w,
  output logic        o_done_w,
  output logic [31:0] o_result_w,
  output logic [3:0]  o_dest_addr_w,
  output logic        o_reg_write_w,
  output logic        o_flags_write_w,
  output logic        o_n_w,
  output logic        o_z_w
);

  localparam int          K     = BITS_PER_CYCLE;
  localparam int          STEPS = 32 / K;
  localparam logic [5:0]  LAST  = 6'(STEPS - 1);

  if (!(K == 1 || K == 2 || K == 4)) begin : g_bad_bits_per_cycle
    $error("mul_iter_unit: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] prod_q;
  logic [31:0] result_q;
  logic [5:0]  count_q;
  logic [3:0]  dest_q;
  logic        sflag_q;
  logic        n_q;
  logic        z_q;

  logic [31:0] partial;
  logic [31:0] prod_d;
  logic [31:0] mplier_d;
  logic        last_step;
  logic        accept;

  // Partial product for the low multiplier group and the RUN exit test.
  always_comb begin
    partial = '0;
    for (int i = 0; i < K; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
    prod_d    = prod_q + partial;
    mplier_d  = mplier_q >> K;
    last_step = (count_q == LAST) || (EARLY_TERM && (mplier_d == '0));
  end

  assign accept = i_start_w && (state_q != RUN);

  // State machine and datapath; result/flags are captured on the last RUN step.
  always_ff @(posedge i_clk_w or posedge i_rst_w) begin
    if (i_rst_w) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      dest_q   <= '0;
      sflag_q  <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << K;
          mplier_q <= mplier_d;
          count_q  <= count_q + 6'd1;
          if (last_step) begin
            state_q  <= DONE;
            result_q <= prod_d;
            n_q      <= prod_d[31];
            z_q      <= (prod_d == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation.
          if (accept) begin
            state_q  <= RUN;
            mcand_q  <= i_op_a_w;
            mplier_q <= i_op_b_w;
            prod_q   <= i_accumulate_w ? i_acc_w : 32'd0;
            dest_q   <= i_dest_addr_w;
            sflag_q  <= i_set_flags_w;
            count_q  <= '0;
          end else begin
            state_q  <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy_w        = (state_q == RUN);
  assign o_stall_w       = (state_q == RUN) | (i_start_w & (state_q != RUN));
  assign o_done_w        = (state_q == DONE);
  assign o_result_w      = result_q;
  assign o_dest_addr_w   = dest_q;
  // R15 is never written by this unit.
  assign o_reg_write_w   = (state_q == DONE) && (dest_q != 4'd15);
  assign o_flags_write_w = (state_q == DONE) && sflag_q;
  assign o_n_w           = n_q;
  assign o_z_w           = z_q;

endmodule
